// File: rtl/wide_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_seq_pkg
// Description : Shared types and constants for the nibble-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package wide_add_seq_pkg;

   // Width of the shared adder slice; operands are processed one slice per cycle
   localparam int NIB_W = 4;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : wide_add_seq_pkg
`default_nettype wire

// File: rtl/wide_add_seq_nibble_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder
// Description : 4-bit ripple adder slice with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder
   import wide_add_seq_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             cout
);

   logic [NIB_W:0] w_full;

   // One extra bit captures the carry out of the slice
   assign w_full = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
   assign sum    = w_full[NIB_W-1:0];
   assign cout   = w_full[NIB_W];

endmodule : nibble_adder
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_seq
// Description : Sequential wide add/subtract using a single shared nibble
//               adder, LSB nibble first, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_add_seq
   import wide_add_seq_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTEP  = WIDTH / NIB_W;
   localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_accept;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic                r_sub;
   logic                r_carry;
   logic [STEP_W-1:0]   r_step;
   logic [WIDTH-1:0]    r_result;
   logic                r_cout;
   logic                r_ovf;
   logic [NIB_W-1:0]    w_a_nib;
   logic [NIB_W-1:0]    w_b_nib;
   logic [NIB_W-1:0]    w_sum;
   logic                w_nib_cout;
   logic                w_msb_cin;
   logic                w_last;

   // Operand slice for the current step; B is inverted for subtraction
   // (the +1 of the two's complement comes from the carry preload)
   assign w_a_nib = r_a[r_step*NIB_W +: NIB_W];
   assign w_b_nib = r_b[r_step*NIB_W +: NIB_W] ^ {NIB_W{r_sub}};
   assign w_last  = (r_step == STEP_W'(NSTEP - 1));

   // Carry into the MSB recovered from the top slice's sum bit
   assign w_msb_cin = w_a_nib[NIB_W-1] ^ w_b_nib[NIB_W-1] ^ w_sum[NIB_W-1];

   nibble_adder u_nibble_adder (
      .a    (w_a_nib),
      .b    (w_b_nib),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_nib_cout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture and one nibble of arithmetic per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_carry  <= 1'b0;
         r_step   <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_a     <= op_a;
         r_b     <= op_b;
         r_sub   <= op_sub;
         r_carry <= op_sub;
         r_step  <= '0;
      end else if (r_state == RUN) begin
         r_result[r_step*NIB_W +: NIB_W] <= w_sum;
         r_carry <= w_nib_cout;
         if (w_last) begin
            r_step <= '0;
            r_cout <= w_nib_cout;
            r_ovf  <= w_msb_cin ^ w_nib_cout;
         end else begin
            r_step <= r_step + 1'b1;
         end
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;

endmodule : wide_add_seq
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_seq
// Description : Directed self-checking bench for wide_add_seq (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         o;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   wide_add_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic on full-width integers
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t         e;
      logic [W-1:0] be;
      logic [W:0]   full;
      be    = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, sub};
      e.res = full[W-1:0];
      e.c   = full[W];
      e.o   = (a[W-1] == be[W-1]) && (e.res[W-1] != a[W-1]);
      return e;
   endfunction

   // Present one operation, handshake on the next rising edge, then scramble inputs
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      op_sub   = sub;
      sb.push_back(model(a, b, sub));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a     = ~a;
      op_b     = b ^ 16'h5A5A;
      op_sub   = ~sub;
   endtask

   // Count cycles until out_valid after the handshake, then compare against the scoreboard
   task automatic await_result(input string tag);
      int   cnt;
      exp_t e;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
         if (!out_valid) check({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      end
      check({tag, "_latency"}, cnt, 32'd4);
      e = sb.pop_front();
      check({tag, "_result"}, {16'd0, result}, {16'd0, e.res});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.o});
   endtask

   // Take the result for one cycle and confirm return to IDLE
   task automatic consume(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] held;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_sub    = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(16'h1234, 16'h4321, 1'b0); await_result("add_basic");  consume("add_basic");
      issue(16'hFFFF, 16'h0001, 1'b0); await_result("add_wrap");   consume("add_wrap");
      issue(16'h7FFF, 16'h0001, 1'b0); await_result("add_ovf");    consume("add_ovf");
      issue(16'h0005, 16'h0007, 1'b1); await_result("sub_borrow"); consume("sub_borrow");
      issue(16'h8000, 16'h0001, 1'b1); await_result("sub_ovf");    consume("sub_ovf");

      // Hold the result with out_ready low; a stray request must be ignored
      issue(16'hA5A5, 16'h1111, 1'b0);
      await_result("hold");
      held = result;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op_a     = 16'h0F0F;
         op_b     = 16'h7070;
         @(posedge clk);
         #1;
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_result", {16'd0, result}, {16'd0, held});
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      consume("hold");

      // Reset while RUN is on step 2: everything returns to reset values
      issue(16'h1111, 16'h2222, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_result", {16'd0, result}, 32'd0);
      check("abort_cout", {31'd0, cout}, 32'd0);
      check("abort_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(16'h0001, 16'h0001, 1'b0); await_result("post_rst"); consume("post_rst");

      // Random mix of adds and subtracts
      for (int k = 0; k < 8; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom_range(0, 1));
         issue(ra, rb, rs);
         await_result("rand");
         consume("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_wide_add_seq
`default_nettype wire

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits; WIDTH SHALL be a multiple of 4, minimum 8.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  requester presents an operation.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port op_a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL have port op_b  input  WIDTH  operand B.
REQ-008 SHALL have port op_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port out_valid  output  1  result held and valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  signed two's-complement overflow.

Function
REQ-014 SHALL compute with one shared 4-bit nibble adder, one nibble per cycle, LSB nibble first; NSTEP = WIDTH/4.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, latch op_a, op_b and op_sub, and load the carry register with op_sub, step counter=0 -> RUN.
REQ-017 RUN: in_ready=0; nibble adder inputs = A nibble[step], B nibble[step] XOR {4{sub}}, carry register; the sum nibble is written to result[step], carry register <= nibble carry, step++.
REQ-018 RUN: on the edge processing step NSTEP-1, latch cout = final carry and ovf = carry into MSB XOR carry out of MSB -> DONE.
REQ-019 Latency: with the handshake on edge E, out_valid SHALL rise after edge E+NSTEP (4 cycles for WIDTH=16).
REQ-020 DONE: out_valid=1; result, cout and ovf stable; in_ready=0; on out_valid&out_ready -> IDLE.
REQ-021 SHALL not accept a new operation in the cycle its result is consumed; the minimum issue interval is NSTEP+2 cycles.
REQ-022 Changes on op_a, op_b or op_sub after the handshake SHALL not affect the result.
REQ-023 Wrap-around: result is modulo 2^WIDTH, with the carry reported only via cout.
REQ-024 out_valid SHALL remain high with outputs unchanged for any number of cycles while out_ready=0.
REQ-025 in_valid while not in IDLE SHALL be ignored with no side effect.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, step=0, and carry register=0.
REQ-027 Reset in RUN or DONE SHALL abort the operation; the partial result SHALL never be presented.
REQ-028 The first handshake after reset release SHALL be on the first rising edge at which rst_n is high and in_valid is high.

Structure
REQ-029 A shared package SHALL hold the FSM state enum {IDLE, RUN, DONE} and the constant NIB_W=4.
REQ-030 SHALL instantiate exactly one sub-module, nibble_adder (a, b, cin -> sum[3:0], cout); all other logic is in wide_add_seq.

Verification
REQ-031 A bench SHALL apply 0x1234 + 0x4321, op_sub=0, and check result 0x5555, cout 0, ovf 0, with out_valid rising exactly 4 cycles after the handshake.
REQ-032 A bench SHALL apply 0xFFFF + 0x0001 and check result 0x0000, cout 1, ovf 0.
REQ-033 A bench SHALL apply 0x7FFF + 0x0001 and check result 0x8000, cout 0, ovf 1.
REQ-034 A bench SHALL apply 0x0005 - 0x0007, op_sub=1, and check result 0xFFFE, cout 0, ovf 0; then 0x8000 - 0x0001 and check result 0x7FFF, cout 1, ovf 1.
REQ-035 A bench SHALL hold out_ready=0 for 10 cycles in DONE and check that out_valid and result are held and in_ready=0; it SHALL then assert out_ready for one cycle and check IDLE with in_ready=1 on the next cycle.
REQ-036 A bench SHALL assert rst_n=0 during RUN step 2 and check all outputs at reset values; after release, 0x0001 + 0x0001 SHALL return 0x0002.
